spi_mstr16: RTL and testbench

SPI_MSTR16 -- requirements
Module: spi_mstr16

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_mstr16.sv | 93 +++++++++
 tb/tb_spi_mstr16.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the 16-bit SPI master: FSM state encoding,
// divider reference points and frame length.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FRONT_PORCH = 2'd1,
        SHIFTING    = 2'd2,
        BACK_PORCH  = 2'd3
    } spi_state_t;

    // SCLK is divider bit 4, so the idle value parks SCLK high.
    localparam logic [4:0] DIV_IDLE    = 5'h1F;
    localparam logic [4:0] DIV_FP_LOAD = 5'h17;
    localparam logic [4:0] DIV_SAMPLE  = 5'h0F;
    localparam int         FRAME_LEN   = 16;

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master, SCLK = clk/32, idle-high clock; MOSI changes on SCLK
// fall, MISO is captured on the clk edge that raises SCLK.
module spi_mstr16
    import spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    spi_state_t  state;
    spi_state_t  state_nxt;
    logic [4:0]  div;
    logic [3:0]  bit_cnt;
    logic [15:0] shft;
    logic        miso_smp;

    logic accept;
    logic div_end;
    logic do_shift;
    logic finish;

    assign accept   = (state == IDLE) && wrt;
    assign div_end  = (div == DIV_IDLE);
    assign do_shift = div_end && ((state == SHIFTING) || (state == BACK_PORCH));
    assign finish   = div_end && (state == BACK_PORCH);

    assign SCLK    = div[4];
    assign MOSI    = shft[15];
    assign rd_data = shft;

    // Leaving SHIFTING on the shift that brings the count to 15; the 16th
    // shift then happens in BACK_PORCH without another SCLK fall.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (wrt) state_nxt = FRONT_PORCH;
            FRONT_PORCH: if (div_end) state_nxt = SHIFTING;
            SHIFTING:    if (div_end && (bit_cnt == 4'(FRAME_LEN - 2))) state_nxt = BACK_PORCH;
            BACK_PORCH:  if (div_end) state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        div <= DIV_IDLE;
        else if (accept)                   div <= DIV_FP_LOAD;
        else if ((state == IDLE) || finish) div <= DIV_IDLE;
        else                               div <= div + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           bit_cnt <= 4'd0;
        else if (accept)                      bit_cnt <= 4'd0;
        else if ((state == SHIFTING) && div_end) bit_cnt <= bit_cnt + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        shft <= 16'h0000;
        else if (accept)   shft <= cmd;
        else if (do_shift) shft <= {shft[14:0], miso_smp};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  miso_smp <= 1'b0;
        else if (div == DIV_SAMPLE)  miso_smp <= MISO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      SS_n <= 1'b1;
        else if (accept) SS_n <= 1'b0;
        else if (finish) SS_n <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      done <= 1'b0;
        else if (accept) done <= 1'b0;
        else if (finish) done <= 1'b1;
    end

endmodule

// File: tb/tb_spi_mstr16.sv
// Bench for spi_mstr16: mode-3 style 16-bit slave model, frame-level
// expectations, directed corner cases and randomized frames.
module tb_spi_mstr16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrt = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        done;
    logic [15:0] rd_data;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_q[$];

    // Slave model state
    bit          loopback = 1'b0;
    logic [15:0] slv_tx = 16'h0000;
    logic [15:0] slv_sh = 16'h0000;
    logic [15:0] slv_rx = 16'h0000;
    int          rise_cnt = 0;
    int          fall_cnt = 0;
    int          idle_toggles = 0;
    int          idle_base = 0;
    logic        ss_prev = 1'b1;
    logic        sclk_prev = 1'b1;

    spi_mstr16 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    always #5 clk = ~clk;

    assign MISO = loopback ? MOSI : (SS_n ? 1'b0 : slv_sh[15]);

    // Slave: loads its word when selected, captures MOSI on SCLK rise,
    // moves to its next bit on each SCLK fall that follows a rise.
    always @(SCLK or SS_n) begin
        if ((SS_n !== ss_prev) && (SS_n == 1'b0)) begin
            slv_sh   = slv_tx;
            slv_rx   = 16'h0000;
            rise_cnt = 0;
            fall_cnt = 0;
        end
        if (SCLK !== sclk_prev) begin
            if (SS_n) begin
                idle_toggles = idle_toggles + 1;
            end else if (SCLK) begin
                slv_rx   = {slv_rx[14:0], MOSI};
                rise_cnt = rise_cnt + 1;
            end else begin
                fall_cnt = fall_cnt + 1;
                if (rise_cnt > 0) slv_sh = {slv_sh[14:0], 1'b0};
            end
        end
        ss_prev   = SS_n;
        sclk_prev = SCLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One wrt-started frame. inj_at: cycle after acceptance at which a stray
    // wrt(cmd=FFFF) is sampled; abort_at: cycle after which reset is pulsed;
    // wrt_at_done: raise wrt on the edge that sets done.
    task automatic run_frame(input logic [15:0] c, input logic [15:0] tx, input bit loop,
                             input int inj_at, input int abort_at, input bit wrt_at_done);
        int          done_cyc;
        logic [15:0] exp;
        loopback = loop;
        slv_tx   = tx;
        exp_q.push_back(loop ? c : tx);
        idle_base = idle_toggles;
        @(negedge clk);
        cmd = c;
        wrt = 1'b1;
        @(posedge clk);
        #1;
        wrt = 1'b0;
        cmd = 16'($urandom);
        check("ss_low_e1", 32'(SS_n), 0);
        check("sclk_high_e1", 32'(SCLK), 1);
        check("done_clr_e1", 32'(done), 0);
        done_cyc = -1;
        for (int cyc = 1; cyc <= 600 && done_cyc < 0; cyc++) begin
            if (cyc == inj_at) begin
                wrt = 1'b1;
                cmd = 16'hFFFF;
            end
            if (wrt_at_done && cyc == 521) wrt = 1'b1;
            @(posedge clk);
            #1;
            if (cyc == inj_at) wrt = 1'b0;
            if (wrt_at_done && cyc == 521) wrt = 1'b0;
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_ss_n", 32'(SS_n), 1);
                check("abort_sclk", 32'(SCLK), 1);
                check("abort_done", 32'(done), 0);
                check("abort_rd_data", 32'(rd_data), 0);
                void'(exp_q.pop_back());
                repeat (3) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                idle_base = idle_toggles;
                return;
            end
            if (done) done_cyc = cyc;
        end
        check("done_cycle", 32'(done_cyc), 521);
        check("sclk_rises", 32'(rise_cnt), 16);
        check("sclk_falls", 32'(fall_cnt), 16);
        check("ss_n_end", 32'(SS_n), 1);
        check("sclk_end", 32'(SCLK), 1);
        exp = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(exp));
        if (!loop) check("slave_rx", 32'(slv_rx), 32'(c));
        repeat (5) @(posedge clk);
        #1;
        check("done_held", 32'(done), 1);
        check("rd_data_held", 32'(rd_data), 32'(exp));
        check("ss_n_idle", 32'(SS_n), 1);
        check("idle_sclk_quiet", 32'(idle_toggles - idle_base), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] prev_rx;
        logic [15:0] rc;
        logic [15:0] rt;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", 32'(SS_n), 1);
        check("rst_sclk", 32'(SCLK), 1);
        check("rst_done", 32'(done), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_mosi", 32'(MOSI), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(16'h1234, 16'hABCD, 1'b0, 0, 0, 1'b0);
        prev_rx = slv_rx;
        run_frame(16'h5A5A, prev_rx, 1'b0, 0, 0, 1'b0);

        // stray wrt mid-frame
        run_frame(16'h3C96, 16'($urandom), 1'b0, 100, 0, 1'b0);

        // reset mid-frame, then a clean frame
        run_frame(16'hC3C3, 16'($urandom), 1'b0, 0, 300, 1'b0);
        run_frame(16'h00FF, 16'h9E37, 1'b0, 0, 0, 1'b0);

        // wrt on the done edge is dropped
        run_frame(16'h7E81, 16'h1F2E, 1'b0, 0, 0, 1'b1);

        // loopback alignment
        run_frame(16'h8001, 16'h0000, 1'b1, 0, 0, 1'b0);
        run_frame(16'h0000, 16'h0000, 1'b1, 0, 0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            rc = 16'($urandom);
            rt = 16'($urandom);
            repeat ($urandom_range(0, 6)) @(negedge clk);
            run_frame(rc, rt, 1'($urandom_range(0, 1)), 0, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
